muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the five-stage pipeline; owns the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU from the Execute stage and runs an iterative shift-add multiply or restoring divide. It raises `stall_md` to the hazard unit, which ORs it into StallF, StallD and FlushE, whenever Decode needs HI/LO or issues another mul/div while the unit is busy.

## Interface
- `WIDTH`, default 32: operand width. HI/LO are each WIDTH bits.
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start_e`  in  1  valid mul/div in Execute, already qualified by stall/flush
- `op_e`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `src_a_e`  in  WIDTH  rs operand (multiplicand/dividend)
- `src_b_e`  in  WIDTH  rt operand (multiplier/divisor)
- `hilo_read_d`  in  1  Decode holds MFHI/MFLO
- `muldiv_d`  in  1  Decode holds a mul/div
- `stall_md`  out  1  stall request to hazard unit
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse when HI/LO are updated
- `div_by_zero`  out  1  pulse with `done` for a divide with rt=0
- `hi`, `lo`  out  WIDTH  architectural HI/LO

## Operation
- FSM states: IDLE, RUN, SIGN.
- IDLE with `start_e`=1:
  - Latch |a| and |b|. Magnitudes are used only for signed ops; the MSB is the sign.
  - Record `neg_p` = sa^sb and `neg_r` = sa.
  - Clear the 2·WIDTH accumulator and the counter, then go to RUN.
- RUN, multiply: each cycle, if multiplier bit0 is 1, add the multiplicand to the upper half; then shift right one.
- RUN, divide: each cycle, shift the remainder:quotient left one and trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit0.
- RUN exit: after WIDTH iterations (counter WIDTH-1 → SIGN).
- SIGN:
  - Multiply: negate the 2·WIDTH product if `neg_p`.
  - Divide: negate the quotient if `neg_p`; negate the remainder if `neg_r`.
  - Write HI (product upper / remainder) and LO (product lower / quotient).
  - Pulse `done` and go to IDLE.
- Divide by zero: IDLE → SIGN directly, skipping RUN. Result is HI = src_a_e and LO = all ones, with `div_by_zero` pulsed.
- Signed overflow (−2^(W−1) / −1): no special case. The result is LO = 0x80000000 and HI = 0.
- `start_e` while busy: ignored. It cannot occur legally because `stall_md` blocks it.
- `stall_md` = `busy` & (`hilo_read_d` | `muldiv_d`). This is combinational and registered-free.
- `hi` and `lo` hold their previous values throughout an operation.
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, counter 0.

## Timing
- Edge 0 samples `start_e`. From edge 0, `busy`=1.
- Edges 1..WIDTH perform the iterations. Edge WIDTH+1 (SIGN) writes HI/LO.
- After edge WIDTH+1: `busy`=0 and `done`=1 for exactly one cycle.
- `busy` is high for WIDTH+1 cycles (33 at default). For divide-by-zero it is high for 1 cycle.
- A new `start_e` is accepted in the cycle `done`=1 (back-to-back ops).
- MFHI/MFLO leaving Decode after `stall_md` falls sees the final HI/LO.
- `rst_n` low mid-operation: immediate return to IDLE and all outputs go to reset values. The partial result is discarded.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: multiply uses a single-cycle WIDTH×WIDTH product in RUN. The RUN state lasts 1 cycle, `busy` lasts 2 cycles, and the multiply result appears after edge 2. Divide is unchanged.
- Macro undefined: iterative multiply as above, with no multiplier inferred.

## Structure
- Shared package `cpu_pkg` holds:
  - the `op_e` encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - the FSM state enum (ST_IDLE, ST_RUN, ST_SIGN)
  - the `WIDTH` default constant
- One sub-module, `muldiv_step`: combinational single-iteration unit (add-shift or subtract-shift selected by an op bit). `muldiv_ctrl` owns the FSM, counter, sign fixup and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, `done` pulse.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 → `busy` 1 cycle, `div_by_zero`=1 with `done`, HI=0x00000007, LO=0xFFFFFFFF.
- `hilo_read_d`=1 held during an operation:
  - `stall_md`=1 on every busy cycle and 0 in the `done` cycle.
  - HI/LO keep their old values until edge 33.
- `rst_n` pulsed low at cycle 10 of a DIV → `busy`=0, HI=LO=0 immediately. A new MULTU 2×3 then gives LO=6, HI=0.
- Back-to-back: MULTU 4×5 with DIVU 20/3 issued in the `done` cycle → LO=20 first, then LO=6, HI=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: mul/div opcode encodings, sequencer state
// encoding and the default datapath width.
package cpu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply step or restoring
// divide step on the 2*WIDTH accumulator.
module muldiv_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   d_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: the multiplier sits in the low half and is consumed from bit0.
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, d_i} : '0);
    diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, d_i};
    if (is_div_i)
      acc_o = diff[WIDTH] ? {acc_i[2*WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    else
      acc_o = {sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply in RUN.
module muldiv_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  input  logic             hilo_read_d,
  input  logic             muldiv_d,
  output logic             stall_md,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   d_q, hi_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, dbz_q, dbz_pend_q;
  logic               is_div_q, neg_p_q, neg_r_q;

  logic               op_div, op_signed, b_zero, run_last;
  logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [2*WIDTH-1:0] step_acc, acc_run, prod;

  assign op_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign op_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign b_zero    = (src_b_e == '0);
  assign mag_a     = (op_signed && src_a_e[WIDTH-1]) ? -src_a_e : src_a_e;
  assign mag_b     = (op_signed && src_b_e[WIDTH-1]) ? -src_b_e : src_b_e;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .d_i      (d_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    acc_run  = step_acc;
    run_last = (cnt_q == CW'(WIDTH-1));
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div_q) begin
      acc_run  = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, d_q};
      run_last = 1'b1;
    end
`endif
  end

  always_comb begin
    prod   = neg_p_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (dbz_pend_q) begin
      // Divide by zero: dividend passes through raw, quotient saturates.
      res_hi = acc_q[WIDTH-1:0];
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_lo = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      d_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
      is_div_q   <= 1'b0;
      neg_p_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_e) begin
          busy_q   <= 1'b1;
          cnt_q    <= '0;
          is_div_q <= op_div;
          neg_p_q  <= op_signed & (src_a_e[WIDTH-1] ^ src_b_e[WIDTH-1]);
          neg_r_q  <= op_signed & src_a_e[WIDTH-1];
          if (op_div && b_zero) begin
            dbz_pend_q <= 1'b1;
            acc_q      <= {{WIDTH{1'b0}}, src_a_e};
            state_q    <= ST_SIGN;
          end else begin
            dbz_pend_q <= 1'b0;
            acc_q      <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
            d_q        <= op_div ? mag_b : mag_a;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_run;
          cnt_q <= cnt_q + CW'(1);
          if (run_last) state_q <= ST_SIGN;
        end
        ST_SIGN: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          dbz_q   <= dbz_pend_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_md    = busy_q & (hilo_read_d | muldiv_d);
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed vector bench for muldiv_ctrl: table of ops plus hand sequences
// for stall, mid-op reset and back-to-back issue.
module tb_muldiv_ctrl;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = W + 1;
`endif
  localparam int DIV_CYC = W + 1;

  logic         clk = 1'b0;
  logic         rst_n, start_e, hilo_read_d, muldiv_d;
  logic [1:0]   op_e;
  logic [W-1:0] src_a_e, src_b_e, hi, lo;
  logic         stall_md, busy, done, div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] old_hi, old_lo;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_e(start_e), .op_e(op_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .hilo_read_d(hilo_read_d),
    .muldiv_d(muldiv_d), .stall_md(stall_md), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, ehi, elo;
    logic         edbz;
    int           ecyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; leaves start deasserted one cycle after edge 0.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_e = 1'b1; op_e = op; src_a_e = a; src_b_e = b;
    old_hi = hi; old_lo = lo;
    @(negedge clk);
    start_e = 1'b0;
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_check(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input logic edbz, input int ecyc);
    int  n = 0;
    bit  held = 1, stall_ok = 1;
    while (busy === 1'b1 && n < 200) begin
      if (hi !== old_hi || lo !== old_lo) held = 0;
      if (stall_md !== (hilo_read_d | muldiv_d)) stall_ok = 0;
      n++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, n, ecyc);
    chk({name, " hold"}, held, 1);
    chk({name, " stall_busy"}, stall_ok, 1);
    chk({name, " done"}, done, 1);
    chk({name, " stall_done"}, stall_md, 0);
    chk({name, " dbz"}, div_by_zero, edbz);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
  endtask

  initial begin
    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_CYC};
    vecs[1] = '{2'b00, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MUL_CYC};
    vecs[2] = '{2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_CYC};
    vecs[3] = '{2'b11, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, DIV_CYC};
    vecs[5] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_CYC};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, MUL_CYC};
    vecs[7] = '{2'b10, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 1'b0, DIV_CYC};
    vecs[8] = '{2'b01, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, MUL_CYC};
    vecs[9] = '{2'b10, -32'sd7, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1};

    rst_n = 1'b0; start_e = 1'b0; op_e = 2'b00; src_a_e = '0; src_b_e = '0;
    hilo_read_d = 1'b0; muldiv_d = 1'b0;
    repeat (2) @(negedge clk);
    hilo_read_d = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst dbz", div_by_zero, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("idle stall", stall_md, 0);
    hilo_read_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_check($sformatf("vec%0d", i), vecs[i].ehi, vecs[i].elo, vecs[i].edbz, vecs[i].ecyc);
      @(negedge clk);
      chk($sformatf("vec%0d done_fall", i), done, 0);
    end

    // Decode holds MFHI for the whole op: stall every busy cycle, HI/LO held.
    hilo_read_d = 1'b1;
    issue(2'b01, 32'd3, 32'd3);
    chk("hilo stall_first", stall_md, 1);
    wait_check("hilo", 32'd0, 32'd9, 1'b0, MUL_CYC);
    hilo_read_d = 1'b0;
    muldiv_d = 1'b1;
    @(negedge clk);
    issue(2'b11, 32'd9, 32'd2);
    chk("muldiv stall", stall_md, 1);
    wait_check("muldiv", 32'd1, 32'd4, 1'b0, DIV_CYC);
    muldiv_d = 1'b0;

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    issue(2'b10, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    chk("midop busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midop busy", busy, 0);
    chk("midop hi", hi, 0);
    chk("midop lo", lo, 0);
    chk("midop done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd2, 32'd3);
    wait_check("post_rst", 32'd0, 32'd6, 1'b0, MUL_CYC);

    // Back-to-back: DIVU issued in the MULTU done cycle.
    @(negedge clk);
    issue(2'b01, 32'd4, 32'd5);
    wait_check("b2b_mul", 32'd0, 32'd20, 1'b0, MUL_CYC);
    issue(2'b11, 32'd20, 32'd3);
    chk("b2b busy", busy, 1);
    wait_check("b2b_div", 32'd2, 32'd6, 1'b0, DIV_CYC);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
